// File: rtl/rv64g_vlsu_pkg.sv
// rtl/rv64g_vlsu_pkg.sv - shared state encoding and address helpers for the VLSU bank scheduler
package rv64g_vlsu_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_MISS  = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   localparam int LINE_OFF_W_DFLT = 6;

   function automatic int bank_idx(input logic [63:0] addr, input int lsb, input int nbanks);
      logic [63:0] sh;
      sh = (addr >> lsb) & 64'(nbanks - 1);
      return int'(sh[31:0]);
   endfunction

   function automatic logic [63:0] word_key(input logic [63:0] addr);
      return {3'b000, addr[63:3]};
   endfunction

   function automatic logic [63:0] line_mask(input int off_w);
      return ~((64'd1 << off_w) - 64'd1);
   endfunction

endpackage

// File: rtl/rv64g_vlsu_prio_pick.sv
// rtl/rv64g_vlsu_prio_pick.sv - lowest-index one-hot select of a lane mask
module rv64g_vlsu_prio_pick
   import rv64g_vlsu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);

   assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/rv64g_vlsu_bank_sched.sv
// rtl/rv64g_vlsu_bank_sched.sv - distributes vector lanes onto L1 data banks with conflict serialisation,
// read coalescing and miss replay
module rv64g_vlsu_bank_sched
   import rv64g_vlsu_pkg::*;
#(
   parameter int NUM_LANES  = 8,
   parameter int NUM_BANKS  = 8,
   parameter int ADDR_W     = 64,
   parameter int BANK_LSB   = 3,
   parameter int LINE_OFF_W = LINE_OFF_W_DFLT,
   parameter int COALESCE   = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          vlsu_req_i,
   input  logic [NUM_LANES-1:0]          vlsu_lane_valid_i,
   input  logic [NUM_LANES-1:0]          vlsu_lane_we_i,
   input  logic [NUM_LANES*ADDR_W-1:0]   vlsu_lane_addr_i,
   input  logic [NUM_LANES*64-1:0]       vlsu_lane_wdata_i,
   input  logic [NUM_LANES*8-1:0]        vlsu_lane_be_i,
   output logic                          vlsu_ready_o,
   output logic                          vlsu_done_o,
   output logic [NUM_LANES-1:0]          vlsu_lane_done_o,
   output logic [NUM_LANES-1:0]          vlsu_lane_hit_o,
   output logic [NUM_LANES*64-1:0]       vlsu_lane_rdata_o,
   output logic [NUM_BANKS-1:0]          bank_req_valid_o,
   input  logic [NUM_BANKS-1:0]          bank_req_gnt_i,
   output logic [NUM_BANKS-1:0]          bank_req_we_o,
   output logic [NUM_BANKS*ADDR_W-1:0]   bank_req_addr_o,
   output logic [NUM_BANKS*64-1:0]       bank_req_wdata_o,
   output logic [NUM_BANKS*8-1:0]        bank_req_be_o,
   input  logic [NUM_BANKS-1:0]          bank_rsp_valid_i,
   input  logic [NUM_BANKS-1:0]          bank_rsp_hit_i,
   input  logic [NUM_BANKS*64-1:0]       bank_rsp_rdata_i,
   output logic                          miss_req_o,
   output logic [ADDR_W-1:0]             miss_addr_o,
   input  logic                          miss_done_i
);

   localparam logic [63:0] LINE_MASK = line_mask(LINE_OFF_W);

   state_t                 state_q, state_d;
   logic [NUM_LANES-1:0]   pend_q, pend_d, infl_q, infl_d, miss_q, miss_d;
   logic [NUM_LANES-1:0]   wait_q, wait_d, done_q, done_d, hit_q, hit_d, we_q;
   logic [NUM_BANKS-1:0]   out_q, out_d;
   logic [ADDR_W-1:0]      addr_q  [NUM_LANES];
   logic [63:0]            wdata_q [NUM_LANES];
   logic [7:0]             be_q    [NUM_LANES];
   logic [63:0]            rdata_q [NUM_LANES];
   logic [63:0]            rdata_d [NUM_LANES];

   logic [63:0]            key     [NUM_LANES];
   logic [63:0]            line    [NUM_LANES];
   logic [NUM_LANES-1:0]   bank_mask [NUM_BANKS];
   logic [NUM_LANES-1:0]   pick      [NUM_BANKS];
   logic [ADDR_W-1:0]      sel_addr  [NUM_BANKS];
   logic [63:0]            sel_wdata [NUM_BANKS];
   logic [7:0]             sel_be    [NUM_BANKS];
   logic [63:0]            sel_key   [NUM_BANKS];
   logic [NUM_BANKS-1:0]   sel_we, req_v;
   logic [NUM_LANES-1:0]   issue_set;
   logic [63:0]            miss_line;
   logic                   accept;

   assign accept = (state_q == ST_IDLE) && vlsu_req_i;

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) bank_mask[b] = '0;
      for (int j = 0; j < NUM_LANES; j++) begin
         key[j]  = word_key(64'(addr_q[j]));
         line[j] = 64'(addr_q[j]) & LINE_MASK;
         for (int b = 0; b < NUM_BANKS; b++)
            if (bank_idx(64'(addr_q[j]), BANK_LSB, NUM_BANKS) == b) bank_mask[b][j] = 1'b1;
      end
   end

   for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
      rv64g_vlsu_prio_pick #(.N(NUM_LANES)) u_pick (
         .req_i (pend_q & bank_mask[gb]),
         .gnt_o (pick[gb])
      );
      assign bank_req_addr_o[gb*ADDR_W +: ADDR_W] = req_v[gb] ? sel_addr[gb]  : '0;
      assign bank_req_wdata_o[gb*64 +: 64]        = req_v[gb] ? sel_wdata[gb] : '0;
      assign bank_req_be_o[gb*8 +: 8]             = req_v[gb] ? sel_be[gb]    : '0;
   end

   for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
      assign vlsu_lane_rdata_o[gl*64 +: 64] = rdata_q[gl];
   end

   // A bank takes a new lane only once its previous access has answered.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         req_v[b]     = (state_q == ST_ISSUE) && !out_q[b] && (|pick[b]);
         sel_addr[b]  = '0;
         sel_wdata[b] = '0;
         sel_be[b]    = '0;
         sel_key[b]   = '0;
         sel_we[b]    = 1'b0;
         for (int j = 0; j < NUM_LANES; j++) begin
            if (pick[b][j]) begin
               sel_addr[b]  = addr_q[j];
               sel_wdata[b] = wdata_q[j];
               sel_be[b]    = be_q[j];
               sel_key[b]   = key[j];
               sel_we[b]    = we_q[j];
            end
         end
      end
   end

   assign bank_req_valid_o = req_v;
   assign bank_req_we_o    = req_v & sel_we;

   always_comb begin
      issue_set = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (req_v[b] && bank_req_gnt_i[b]) begin
            issue_set = issue_set | pick[b];
            if (COALESCE != 0 && !sel_we[b]) begin
               for (int j = 0; j < NUM_LANES; j++)
                  if (pend_q[j] && !we_q[j] && key[j] == sel_key[b]) issue_set[j] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      miss_line = '0;
      for (int j = NUM_LANES - 1; j >= 0; j--)
         if (wait_q[j]) miss_line = line[j];
   end

   assign miss_req_o   = (state_q == ST_MISS);
   assign miss_addr_o  = miss_req_o ? ADDR_W'(miss_line) : '0;
   assign vlsu_ready_o = (state_q == ST_IDLE);
   assign vlsu_done_o  = (state_q == ST_DONE);
   assign vlsu_lane_done_o = done_q;
   assign vlsu_lane_hit_o  = hit_q;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      infl_d  = infl_q;
      miss_d  = miss_q;
      wait_d  = wait_q;
      done_d  = done_q;
      hit_d   = hit_q;
      out_d   = out_q;
      for (int j = 0; j < NUM_LANES; j++) rdata_d[j] = rdata_q[j];

      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_rsp_valid_i[b] && out_q[b]) begin
            out_d[b] = 1'b0;
            for (int j = 0; j < NUM_LANES; j++) begin
               if (infl_q[j] && bank_mask[b][j]) begin
                  infl_d[j] = 1'b0;
                  if (bank_rsp_hit_i[b]) begin
                     done_d[j] = 1'b1;
                     hit_d[j]  = !miss_q[j];
                     if (!we_q[j]) rdata_d[j] = bank_rsp_rdata_i[b*64 +: 64];
                  end else begin
                     miss_d[j] = 1'b1;
                     wait_d[j] = 1'b1;
                  end
               end
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (vlsu_req_i) begin
               pend_d  = vlsu_lane_valid_i;
               infl_d  = '0;
               miss_d  = '0;
               wait_d  = '0;
               done_d  = '0;
               hit_d   = '0;
               out_d   = '0;
               state_d = (|vlsu_lane_valid_i) ? ST_ISSUE : ST_DONE;
            end
         end
         ST_ISSUE: begin
            out_d  = out_d | (req_v & bank_req_gnt_i);
            pend_d = pend_d & ~issue_set;
            infl_d = infl_d | issue_set;
            if (pend_d == '0 && infl_d == '0) state_d = (|wait_d) ? ST_MISS : ST_DONE;
         end
         ST_MISS: begin
            if (miss_done_i) begin
               for (int j = 0; j < NUM_LANES; j++) begin
                  if (wait_q[j] && line[j] == miss_line) begin
                     pend_d[j] = 1'b1;
                     wait_d[j] = 1'b0;
                  end
               end
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         infl_q  <= '0;
         miss_q  <= '0;
         wait_q  <= '0;
         done_q  <= '0;
         hit_q   <= '0;
         out_q   <= '0;
         we_q    <= '0;
         for (int j = 0; j < NUM_LANES; j++) begin
            rdata_q[j] <= '0;
            addr_q[j]  <= '0;
            wdata_q[j] <= '0;
            be_q[j]    <= '0;
         end
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         infl_q  <= infl_d;
         miss_q  <= miss_d;
         wait_q  <= wait_d;
         done_q  <= done_d;
         hit_q   <= hit_d;
         out_q   <= out_d;
         for (int j = 0; j < NUM_LANES; j++) rdata_q[j] <= rdata_d[j];
         if (accept) begin
            we_q <= vlsu_lane_we_i;
            for (int j = 0; j < NUM_LANES; j++) begin
               addr_q[j]  <= vlsu_lane_addr_i[j*ADDR_W +: ADDR_W];
               wdata_q[j] <= vlsu_lane_wdata_i[j*64 +: 64];
               be_q[j]    <= vlsu_lane_be_i[j*8 +: 8];
            end
         end
      end
   end

endmodule
